// File: rtl/psram_sched_pkg.sv
// psram_sched_pkg: shared widths, FSM states and ownership encoding for the PSRAM scheduler.
package psram_sched_pkg;
  localparam int LEN_W  = 11;
  localparam int ADDR_W = 24;
  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_ISSUE, S_BUSY, S_COMPLETE} sched_state_e;
  typedef enum logic [1:0] {OWNER_NONE = 2'd0, OWNER_VIDEO = 2'd1, OWNER_HOST = 2'd2} owner_e;
endpackage

// File: rtl/psram_access_scheduler_if.sv
// psram_access_scheduler_if: requester, host data and engine signals around the scheduler.
interface psram_access_scheduler_if;
  import psram_sched_pkg::*;
  logic              init_done;
  logic              vid_req, vid_ack, vid_done, vid_rvalid;
  logic [ADDR_W-1:0] vid_addr;
  logic [LEN_W-1:0]  vid_len;
  logic [7:0]        vid_rdata;
  logic              host_req, host_rw, host_ack, host_done, host_wready, host_rvalid;
  logic [ADDR_W-1:0] host_addr;
  logic [LEN_W-1:0]  host_len;
  logic [7:0]        host_wdata, host_rdata;
  logic              eng_cmd_valid, eng_cmd_ready, eng_cmd_rw, eng_done, eng_wready, eng_rvalid;
  logic [ADDR_W-1:0] eng_cmd_addr;
  logic [LEN_W-1:0]  eng_cmd_len;
  logic [7:0]        eng_wdata, eng_rdata;
  logic [1:0]        owner;
  modport slave (
    input  init_done, vid_req, vid_addr, vid_len, host_req, host_rw, host_addr, host_len,
           host_wdata, eng_cmd_ready, eng_done, eng_wready, eng_rdata, eng_rvalid,
    output vid_ack, vid_done, vid_rdata, vid_rvalid, host_ack, host_done, host_wready,
           host_rdata, host_rvalid, eng_cmd_valid, eng_cmd_rw, eng_cmd_addr, eng_cmd_len,
           eng_wdata, owner
  );
  modport master (
    output init_done, vid_req, vid_addr, vid_len, host_req, host_rw, host_addr, host_len,
           host_wdata, eng_cmd_ready, eng_done, eng_wready, eng_rdata, eng_rvalid,
    input  vid_ack, vid_done, vid_rdata, vid_rvalid, host_ack, host_done, host_wready,
           host_rdata, host_rvalid, eng_cmd_valid, eng_cmd_rw, eng_cmd_addr, eng_cmd_len,
           eng_wdata, owner
  );
endinterface

// File: rtl/psram_chunk_calc.sv
// psram_chunk_calc: next burst size = min(remaining, MAX_BURST, bytes left in the current page).
module psram_chunk_calc
  import psram_sched_pkg::*;
#(
  parameter int MAX_BURST  = 32,
  parameter int PAGE_BYTES = 1024
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  rem,
  output logic [LEN_W-1:0]  chunk
);
  logic [LEN_W-1:0] page_rem, cap;
  assign page_rem = LEN_W'(PAGE_BYTES) - LEN_W'(addr % ADDR_W'(PAGE_BYTES));
  assign cap      = page_rem < LEN_W'(MAX_BURST) ? page_rem : LEN_W'(MAX_BURST);
  assign chunk    = rem < cap ? rem : cap;
endmodule

// File: rtl/psram_access_scheduler.sv
// psram_access_scheduler: arbitrates video/host onto one PSRAM engine, splitting requests into
// page-safe bursts of at most MAX_BURST bytes.
module psram_access_scheduler
  import psram_sched_pkg::*;
#(
  parameter int MAX_BURST         = 32,
  parameter int PAGE_BYTES        = 1024,
  parameter int HOST_STARVE_LIMIT = 4
) (
  input logic                     sysclk,
  input logic                     reset,
  psram_access_scheduler_if.slave bus
);
  localparam int SW = $clog2(HOST_STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(HOST_STARVE_LIMIT);
  sched_state_e      state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d, chunk;
  logic [SW-1:0]     starve_q, starve_d;
  logic              grant, host_win, issue, busy, fin, vid_rd, host_rd, host_wr;
  psram_chunk_calc #(.MAX_BURST(MAX_BURST), .PAGE_BYTES(PAGE_BYTES)) u_chunk (
    .addr (addr_q),
    .rem  (rem_q),
    .chunk(chunk)
  );
  assign grant    = state_q == S_IDLE && bus.init_done && (bus.vid_req || bus.host_req);
  assign host_win = bus.host_req && (!bus.vid_req || starve_q == STARVE_MAX);
  assign issue    = state_q == S_ISSUE;
  assign busy     = state_q == S_BUSY;
  assign fin      = state_q == S_COMPLETE;
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    starve_d = starve_q;
    case (state_q)
      S_IDLE: if (grant) begin
        state_d  = S_GRANT;
        owner_d  = host_win ? OWNER_HOST : OWNER_VIDEO;
        rw_d     = host_win && bus.host_rw;
        addr_d   = host_win ? bus.host_addr : bus.vid_addr;
        rem_d    = host_win ? bus.host_len : bus.vid_len;
        starve_d = host_win ? '0 : (bus.host_req && starve_q != STARVE_MAX) ? starve_q + 1'b1 : starve_q;
      end
      S_GRANT:    state_d = rem_q == '0 ? S_COMPLETE : S_ISSUE;
      S_ISSUE:    state_d = bus.eng_cmd_valid && bus.eng_cmd_ready ? S_BUSY : S_ISSUE;
      S_BUSY: if (bus.eng_done) begin
        addr_d  = addr_q + ADDR_W'(chunk);
        rem_d   = rem_q - chunk;
        state_d = rem_q == chunk ? S_COMPLETE : S_ISSUE;
      end
      S_COMPLETE: begin
        state_d = S_IDLE;
        owner_d = OWNER_NONE;
      end
      default:    state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      owner_q  <= OWNER_NONE;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      rem_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      starve_q <= starve_d;
    end
  end
  // Data is routed only while a burst is in flight; stray engine read beats go nowhere.
  assign vid_rd  = busy && owner_q == OWNER_VIDEO;
  assign host_rd = busy && owner_q == OWNER_HOST && !rw_q;
  assign host_wr = busy && owner_q == OWNER_HOST && rw_q;
  assign bus.vid_ack       = grant && !host_win;
  assign bus.host_ack      = grant && host_win;
  assign bus.vid_done      = fin && owner_q == OWNER_VIDEO;
  assign bus.host_done     = fin && owner_q == OWNER_HOST;
  assign bus.vid_rvalid    = vid_rd && bus.eng_rvalid;
  assign bus.vid_rdata     = vid_rd ? bus.eng_rdata : '0;
  assign bus.host_rvalid   = host_rd && bus.eng_rvalid;
  assign bus.host_rdata    = host_rd ? bus.eng_rdata : '0;
  assign bus.host_wready   = host_wr && bus.eng_wready;
  assign bus.eng_wdata     = host_wr ? bus.host_wdata : '0;
  assign bus.eng_cmd_valid = issue && bus.init_done;
  assign bus.eng_cmd_rw    = issue && rw_q;
  assign bus.eng_cmd_addr  = issue ? addr_q : '0;
  assign bus.eng_cmd_len   = issue ? chunk : '0;
  assign bus.owner         = owner_q;
endmodule
